// File: rtl/pic_pkg.sv
// pic_pkg: shared constants, OCW2 command codes, FSM states and level helpers for the 8259A-style controller
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam int LVL_W  = 3;
  localparam logic [2:0] NS_EOI     = 3'b001;
  localparam logic [2:0] NOP        = 3'b010;
  localparam logic [2:0] SP_EOI     = 3'b011;
  localparam logic [2:0] ROT_NS_EOI = 3'b101;
  localparam logic [2:0] SET_PRI    = 3'b110;
  localparam logic [2:0] ROT_SP_EOI = 3'b111;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK1 = 2'd2;
  localparam logic [1:0] ST_ACK2 = 2'd3;
  function automatic logic [LVL_W-1:0] onehot_to_lvl(input logic [NUM_IR-1:0] oh);
    logic [LVL_W-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_IR; i++) l |= oh[i] ? LVL_W'(i) : '0;
    return l;
  endfunction
  function automatic logic [NUM_IR-1:0] lvl_to_onehot(input logic [LVL_W-1:0] l);
    return NUM_IR'(1) << l;
  endfunction
endpackage

// File: rtl/rot_priority_pick.sv
// rot_priority_pick: highest-priority set bit of vec when level rot is the lowest priority
//  vec   in  8  candidate bits
//  rot   in  3  lowest-priority level
//  valid out 1  any bit set
//  lvl   out 3  winning level
module rot_priority_pick
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [LVL_W-1:0]  rot,
  output logic              valid,
  output logic [LVL_W-1:0]  lvl
);
  logic [LVL_W-1:0]  sh;
  logic [LVL_W-1:0]  pos;
  logic [NUM_IR-1:0] rv;
  // Rotate so the highest-priority level (rot+1) lands on bit 0, then take the lowest set bit.
  assign sh = rot + LVL_W'(1);
  assign rv = NUM_IR'({vec, vec} >> sh);
  always_comb begin
    pos = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) pos = rv[i] ? LVL_W'(i) : pos;
  end
  assign valid = |vec;
  assign lvl   = pos + sh;
endmodule

// File: rtl/in_service_control.sv
// in_service_control: raises INT, runs the two-pulse INTA cycle, maintains ISR and the rotation point
//  clk, reset_n                 clock, async active-low reset
//  interrupt                    one-hot resolved request (0 = none)
//  inta_n                       synchronised CPU acknowledge, active-low
//  auto_eoi, rotate_on_aeoi     automatic EOI and rotation at the end of the second INTA
//  vector_base                  T7..T3 of the vector byte
//  eoi_valid, eoi_cmd, eoi_level OCW2 command strobe and operands
//  int_out                      INT to the CPU
//  clear_irr                    one-cycle IRR clear pulse
//  data_out, data_out_en        vector byte and its drive enable
//  in_service_register          ISR
//  highest_level_in_service     one-hot rotation point (lowest priority level)
module in_service_control
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] interrupt,
  input  logic              inta_n,
  input  logic              auto_eoi,
  input  logic              rotate_on_aeoi,
  input  logic [4:0]        vector_base,
  input  logic              eoi_valid,
  input  logic [2:0]        eoi_cmd,
  input  logic [LVL_W-1:0]  eoi_level,
  output logic              int_out,
  output logic [NUM_IR-1:0] clear_irr,
  output logic [7:0]        data_out,
  output logic              data_out_en,
  output logic [NUM_IR-1:0] in_service_register,
  output logic [NUM_IR-1:0] highest_level_in_service
);
  logic [1:0]        state;
  logic              inta_q;
  logic              spur;
  logic [LVL_W-1:0]  lvl;
  logic [LVL_W-1:0]  rot;
  logic              fall;
  logic              rise;
  logic              int_any;
  logic              aeoi_done;
  logic              eoi_act;
  logic              is_ns;
  logic              is_sp;
  logic              eoi_rot;
  logic              pick_valid;
  logic [LVL_W-1:0]  pick_lvl;
  logic [NUM_IR-1:0] set_mask;
  logic [NUM_IR-1:0] aeoi_mask;
  logic [NUM_IR-1:0] eoi_mask;
  rot_priority_pick u_pick (
    .vec   (in_service_register),
    .rot   (rot),
    .valid (pick_valid),
    .lvl   (pick_lvl)
  );
  assign fall      = inta_q & ~inta_n;
  assign rise      = ~inta_q & inta_n;
  assign int_any   = |interrupt;
  assign set_mask  = (state == ST_PEND && fall && int_any) ? lvl_to_onehot(onehot_to_lvl(interrupt)) : '0;
  assign aeoi_done = state == ST_ACK2 && rise && auto_eoi && !spur;
  assign aeoi_mask = aeoi_done ? lvl_to_onehot(lvl) : '0;
  assign eoi_act   = eoi_valid && eoi_cmd != NOP;
  assign is_ns     = eoi_act && (eoi_cmd == NS_EOI || eoi_cmd == ROT_NS_EOI);
  assign is_sp     = eoi_act && (eoi_cmd == SP_EOI || eoi_cmd == ROT_SP_EOI);
  assign eoi_mask  = (is_ns && pick_valid) ? lvl_to_onehot(pick_lvl) : is_sp ? lvl_to_onehot(eoi_level) : '0;
  assign eoi_rot   = eoi_act && ((eoi_cmd == ROT_NS_EOI && pick_valid) || eoi_cmd == ROT_SP_EOI || eoi_cmd == SET_PRI);
  assign highest_level_in_service = lvl_to_onehot(rot);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      inta_q              <= 1'b1;
      spur                <= 1'b0;
      lvl                 <= '0;
      rot                 <= LVL_W'(NUM_IR - 1);
      int_out             <= 1'b0;
      clear_irr           <= '0;
      data_out            <= '0;
      data_out_en         <= 1'b0;
      in_service_register <= '0;
    end else begin
      inta_q              <= inta_n;
      clear_irr           <= set_mask;
      // Clears first so a same-cycle set of the same bit survives.
      in_service_register <= (in_service_register & ~eoi_mask & ~aeoi_mask) | set_mask;
      // An explicit rotating EOI overrides the auto-EOI rotation.
      rot <= eoi_rot ? ((eoi_cmd == ROT_NS_EOI) ? pick_lvl : eoi_level) : (aeoi_done && rotate_on_aeoi) ? lvl : rot;
      case (state)
        ST_IDLE: state <= int_any ? ST_PEND : ST_IDLE;
        ST_PEND:
          if (fall) begin
            lvl     <= int_any ? onehot_to_lvl(interrupt) : LVL_W'(NUM_IR - 1);
            spur    <= !int_any;
            int_out <= 1'b0;
            state   <= ST_ACK1;
          end else if (!int_any) begin
            int_out <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            int_out <= 1'b1;
          end
        ST_ACK1: state <= rise ? ST_ACK2 : ST_ACK1;
        default:
          if (fall) begin
            data_out    <= {vector_base, lvl};
            data_out_en <= 1'b1;
          end else if (rise) begin
            data_out_en <= 1'b0;
            state       <= ST_IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_in_service_control.sv
// tb_in_service_control: randomized scoreboard bench with a behavioural ISR/rotation model
module tb_in_service_control;
  import pic_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic       auto_eoi;
  logic       rotate_on_aeoi;
  logic [4:0] vector_base;
  logic       eoi_valid;
  logic [2:0] eoi_cmd;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [7:0] isr;
  logic [7:0] hlis;
  int passed = 0;
  int total = 0;
  bit [7:0] m_isr = '0;
  int m_rot = 7;
  logic [7:0] exp_vec[$];
  logic [7:0] exp_clr[$];
  bit prev_en = 1'b0;
  in_service_control dut (
    .clk (clk), .reset_n (reset_n), .interrupt (interrupt), .inta_n (inta_n),
    .auto_eoi (auto_eoi), .rotate_on_aeoi (rotate_on_aeoi), .vector_base (vector_base),
    .eoi_valid (eoi_valid), .eoi_cmd (eoi_cmd), .eoi_level (eoi_level),
    .int_out (int_out), .clear_irr (clear_irr), .data_out (data_out), .data_out_en (data_out_en),
    .in_service_register (isr), .highest_level_in_service (hlis)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit m_eoi(input logic [2:0] cmd, input int lv);
    int t;
    t = -1;
    if (cmd == NS_EOI || cmd == ROT_NS_EOI)
      for (int k = 1; k <= 8; k++) if (t < 0 && m_isr[(m_rot + k) % 8]) t = (m_rot + k) % 8;
    if (cmd == SP_EOI || cmd == ROT_SP_EOI) t = lv;
    if (t >= 0) m_isr[t] = 1'b0;
    if ((cmd == ROT_NS_EOI && t >= 0) || cmd == ROT_SP_EOI || cmd == SET_PRI) begin
      m_rot = (cmd == SET_PRI) ? lv : t;
      return 1'b1;
    end
    return 1'b0;
  endfunction
  always @(negedge clk) begin
    if (data_out_en && !prev_en) begin
      if (exp_vec.size() == 0) begin
        total++;
        $display("FAIL vector_unexpected: got %0h, expected no vector", data_out);
      end else chk("vector", data_out, exp_vec.pop_front());
    end
    if (clear_irr != 0) begin
      if (exp_clr.size() == 0) begin
        total++;
        $display("FAIL clear_irr_unexpected: got %0h, expected 0", clear_irr);
      end else chk("clear_irr", clear_irr, exp_clr.pop_front());
    end
    prev_en = data_out_en;
  end
  task automatic eoi(input logic [2:0] cmd, input int lv);
    bit r;
    eoi_valid = 1'b1;
    eoi_cmd = cmd;
    eoi_level = 3'(lv);
    tick();
    eoi_valid = 1'b0;
    r = m_eoi(cmd, lv);
    chk("eoi_isr", isr, m_isr);
    chk("eoi_hlis", hlis, 8'b1 << m_rot);
  endtask
  // coll: 0 none, 1 EOI in the INTA#1 capture cycle, 2 EOI in the INTA#2 release cycle
  task automatic ack(input int lv, input bit spur, input int coll, input logic [2:0] ccmd, input int clv, input bit rst);
    int n;
    bit r;
    n = 0;
    r = 1'b0;
    interrupt = 8'b1 << lv;
    do begin tick(); n++; end while (!int_out && n < 10);
    chk("int_latency", n, 2);
    if (spur) interrupt = '0;
    inta_n = 1'b0;
    if (coll == 1) begin
      eoi_valid = 1'b1; eoi_cmd = ccmd; eoi_level = 3'(clv);
      r = m_eoi(ccmd, clv);
    end
    if (!spur) begin
      m_isr[lv] = 1'b1;
      exp_clr.push_back(8'b1 << lv);
    end
    exp_vec.push_back({vector_base, spur ? 3'd7 : 3'(lv)});
    tick();
    eoi_valid = 1'b0;
    interrupt = '0;
    chk("ack1_int_out", int_out, 0);
    chk("ack1_en", data_out_en, 0);
    chk("ack1_isr", isr, m_isr);
    tick();
    chk("clear_irr_end", clear_irr, 0);
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    chk("ack2_en", data_out_en, 1);
    chk("ack2_int_out", int_out, 0);
    if (rst) begin
      @(negedge clk);
      #2 reset_n = 1'b0;
      inta_n = 1'b1;
      #1;
      chk("rst_en", data_out_en, 0);
      chk("rst_isr", isr, 0);
      chk("rst_int_out", int_out, 0);
      chk("rst_hlis", hlis, 8'h80);
      m_isr = '0;
      m_rot = 7;
      tick();
      reset_n = 1'b1;
      tick();
      return;
    end
    tick();
    inta_n = 1'b1;
    if (coll == 2) begin
      eoi_valid = 1'b1; eoi_cmd = ccmd; eoi_level = 3'(clv);
    end
    tick();
    eoi_valid = 1'b0;
    if (coll == 2) r = m_eoi(ccmd, clv);
    else r = 1'b0;
    if (auto_eoi && !spur) begin
      m_isr[lv] = 1'b0;
      if (rotate_on_aeoi && !r) m_rot = lv;
    end
    chk("ack_done_en", data_out_en, 0);
    chk("ack_done_isr", isr, m_isr);
    chk("ack_done_hlis", hlis, 8'b1 << m_rot);
  endtask
  initial begin
    reset_n = 1'b1; interrupt = '0; inta_n = 1'b1; auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
    vector_base = 5'b01000; eoi_valid = 1'b0; eoi_cmd = NOP; eoi_level = '0;
    #2 reset_n = 1'b0;
    tick();
    chk("reset_int_out", int_out, 0);
    chk("reset_clear_irr", clear_irr, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_en", data_out_en, 0);
    chk("reset_isr", isr, 0);
    chk("reset_hlis", hlis, 8'h80);
    reset_n = 1'b1;
    tick();
    ack(3, 0, 0, NOP, 0, 0);
    chk("plain_isr", isr, 8'h08);
    eoi(SP_EOI, 3);
    auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
    ack(5, 0, 0, NOP, 0, 0);
    chk("aeoi_isr", isr, 8'h00);
    chk("aeoi_hlis", hlis, 8'h20);
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
    ack(4, 1, 0, NOP, 0, 0);
    chk("spur_isr", isr, 8'h00);
    ack(1, 0, 0, NOP, 0, 0);
    ack(7, 0, 0, NOP, 0, 0);
    chk("two_isr", isr, 8'h82);
    eoi(SET_PRI, 0);
    eoi(NS_EOI, 0);
    chk("ns_eoi_isr", isr, 8'h80);
    eoi(ROT_NS_EOI, 0);
    chk("rot_ns_isr", isr, 8'h00);
    chk("rot_ns_hlis", hlis, 8'h80);
    ack(2, 0, 1, SP_EOI, 2, 0);
    chk("collide_isr2", isr[2], 1);
    eoi(SP_EOI, 2);
    ack(6, 0, 0, NOP, 0, 1);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) eoi(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else begin
        auto_eoi = 1'($urandom);
        rotate_on_aeoi = 1'($urandom);
        vector_base = 5'($urandom);
        ack(int'($urandom_range(0, 7)), $urandom_range(0, 5) == 0, int'($urandom_range(0, 2)),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
      end
    end
    tick();
    chk("vec_queue_drained", exp_vec.size(), 0);
    chk("clr_queue_drained", exp_clr.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
